// File: rtl/vga_pkg.sv
// Shared constants for the text-mode video path: screen geometry in
// character cells, glyph size, address widths and the cursor underline row.
package vga_pkg;

  localparam int COLS        = 80;   // text columns (640 / CHAR_W)
  localparam int ROWS        = 30;   // text rows (480 / CHAR_H)
  localparam int CHAR_W      = 8;    // glyph width in pixels
  localparam int CHAR_H      = 16;   // glyph height in lines
  localparam int TADDR_WIDTH = 12;   // text buffer address width
  localparam int FADDR_WIDTH = 11;   // 7-bit ASCII + 4-bit glyph row
  localparam int CURSOR_ROW  = 14;   // first glyph row of the underline cursor

endpackage

// File: rtl/text_pixel_gen_if.sv
// Memory-side bus of the text renderer: text buffer lookup and font lookup.
// Both memories are single-cycle registered reads owned by the slave side.
interface text_pixel_gen_if #(
  parameter int TADDR_WIDTH = 12,
  parameter int FADDR_WIDTH = 11
) ();

  logic [TADDR_WIDTH-1:0] text_addr;  // cell index row*COLS+col
  logic [7:0]             char_code;  // ASCII code from text buffer
  logic [FADDR_WIDTH-1:0] font_addr;  // {char[6:0], glyph_row}
  logic [7:0]             font_row;   // glyph row, index 0 = leftmost pixel

  modport master (
    output text_addr,
    output font_addr,
    input  char_code,
    input  font_row
  );

  modport slave (
    input  text_addr,
    input  font_addr,
    output char_code,
    output font_row
  );

endinterface

// File: rtl/text_pipe_delay.sv
// Fixed-depth shift register for side-band values that must follow a pixel
// through the renderer pipeline. Every stage clears on reset so a flushed
// pipeline never emits stale sync or pixel data.
module text_pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift the input one stage per clock; reset flushes every stage to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q_o = pipe[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel renderer. Turns the timing generator's pixel position into
// a text-buffer cell address, the returned character into a font address,
// and the returned glyph row into one pixel with a blinking underline cursor.
// Sync and blank are delayed to stay aligned with the pixel (4-cycle latency).
module text_pixel_gen
  import vga_pkg::*;
#(
  parameter int COLS         = vga_pkg::COLS,
  parameter int ROWS         = vga_pkg::ROWS,
  parameter int TADDR_WIDTH  = vga_pkg::TADDR_WIDTH,
  parameter int FADDR_WIDTH  = vga_pkg::FADDR_WIDTH,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [9:0]             hcount_i,
  input  logic [9:0]             vcount_i,
  input  logic                   visible_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  text_pixel_gen_if.master       mem,
  input  logic                   cursor_en_i,
  input  logic [TADDR_WIDTH-1:0] cursor_addr_i,
  output logic                   pixel_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   visible_o
);

  localparam int COL_W  = $clog2(CHAR_W);
  localparam int ROW_W  = $clog2(CHAR_H);
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int SB_W   = COL_W + 4;
  localparam int CELLS  = COLS * ROWS;

  // Constant multiply by COLS built from shifted copies of the row index,
  // one per set bit of COLS (80 = 64 + 16). Result wraps at TADDR_WIDTH.
  function automatic logic [TADDR_WIDTH-1:0] mul_cols(input logic [9-ROW_W:0] row);
    logic [TADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int k = 0; k < TADDR_WIDTH; k++) begin
      if (COLS[k]) acc = acc + (TADDR_WIDTH'(row) << k);
    end
    return acc;
  endfunction

  logic [TADDR_WIDTH-1:0] cell_idx;
  logic                   hit_n;
  logic [SB_W-1:0]        sb_p2;
  logic [ROW_W-1:0]       grow_p1;
  logic [COL_W-1:0]       col_p2;
  logic                   hit_p2;
  logic                   hs_p2;
  logic                   vs_p2;
  logic                   vld_p2;
  logic                   vsync_q;
  logic [CNT_W-1:0]       blink_cnt;
  logic                   blink_on;
  logic                   unused_char_msb;

  // Stage N: cell index and cursor hit for the incoming pixel position.
  // Cursor addresses off the screen can never match a visible cell.
  always_comb begin
    cell_idx = mul_cols(vcount_i[9:ROW_W]) + TADDR_WIDTH'(hcount_i[9:COL_W]);
    hit_n    = cursor_en_i & blink_on & (cell_idx == cursor_addr_i)
             & (32'(cursor_addr_i) < CELLS)
             & (vcount_i[ROW_W-1:0] >= ROW_W'(CURSOR_ROW));
  end

  // Register the text buffer address for the cell under the current pixel.
  always_ff @(posedge clk_i) begin
    if (rst_i) mem.text_addr <= '0;
    else       mem.text_addr <= cell_idx;
  end

  // Side-band for the output stage: pixel column, cursor hit, syncs, visible.
  text_pipe_delay #(.WIDTH(SB_W), .DEPTH(3)) u_sb_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({hcount_i[COL_W-1:0], hit_n, hsync_i, vsync_i, visible_i}),
    .q_o   (sb_p2)
  );

  // Glyph row only has to reach the cycle in which char_code is returned.
  text_pipe_delay #(.WIDTH(ROW_W), .DEPTH(2)) u_row_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (vcount_i[ROW_W-1:0]),
    .q_o   (grow_p1)
  );

  // Stage N+2: font address from the returned character; bit 7 is not font data.
  assign mem.font_addr   = FADDR_WIDTH'({mem.char_code[6:0], grow_p1});
  assign unused_char_msb = mem.char_code[7];

  assign col_p2 = sb_p2[SB_W-1 -: COL_W];
  assign hit_p2 = sb_p2[3];
  assign hs_p2  = sb_p2[2];
  assign vs_p2  = sb_p2[1];
  assign vld_p2 = sb_p2[0];

  // Stage N+3: pick the glyph bit, invert under the cursor, blank outside video.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pixel_o   <= 1'b0;
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
      visible_o <= 1'b0;
    end else begin
      pixel_o   <= vld_p2 & (mem.font_row[col_p2] ^ hit_p2);
      hsync_o   <= hs_p2;
      vsync_o   <= vs_p2;
      visible_o <= vld_p2;
    end
  end

  // Cursor blink: count vsync rising edges, toggle every BLINK_FRAMES frames.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q   <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      if (vsync_i && !vsync_q) begin
        if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

endmodule
